// File: rtl/vrf_operand_collector.sv
// Single-entry operand collector between the VRF read-return stage and one vector FU issue slot.
// Optional VOC_MASK_CAPTURE_EN adds v0 mask capture (uop_vm, data_v0, opnd_mask).
module vrf_operand_collector #(
  parameter int unsigned VRF_RPORT_NUM   = 4,
  parameter int unsigned VFULEN          = 64,
  parameter int unsigned SRC_NUM         = 3,
  parameter int unsigned FIELD_NUM       = 2,
  parameter int unsigned TAG_WIDTH       = 6,
  parameter int unsigned RS_IDX_WIDTH    = 2,
  parameter int unsigned FIELD_IDX_WIDTH = 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   flush,
  input  logic                                   uop_vld,
  output logic                                   uop_rdy,
  input  logic [TAG_WIDTH-1:0]                   uop_tag,
  input  logic [SRC_NUM*FIELD_NUM-1:0]           uop_need,
`ifdef VOC_MASK_CAPTURE_EN
  input  logic                                   uop_vm,
  input  logic [FIELD_NUM*VFULEN-1:0]            data_v0,
  output logic [FIELD_NUM*VFULEN-1:0]            opnd_mask,
`endif
  input  logic [VRF_RPORT_NUM-1:0]               rd_vld,
  input  logic [VRF_RPORT_NUM*RS_IDX_WIDTH-1:0]  rd_rs_idx,
  input  logic [VRF_RPORT_NUM*FIELD_IDX_WIDTH-1:0] rd_field_idx,
  input  logic [VRF_RPORT_NUM*VFULEN-1:0]        rd_data,
  output logic                                   opnd_vld,
  input  logic                                   opnd_rdy,
  output logic [TAG_WIDTH-1:0]                   opnd_tag,
  output logic [SRC_NUM*FIELD_NUM*VFULEN-1:0]    opnd_data,
  output logic                                   err_unexp
);

  localparam int unsigned SLOTS = SRC_NUM * FIELD_NUM;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]              state;
  logic [SLOTS-1:0]        need_q;
  logic [SLOTS-1:0]        got_q;
  logic [SLOTS-1:0]        hit;
  logic [SLOTS*VFULEN-1:0] hit_data;
  logic [VRF_RPORT_NUM-1:0] port_ok;
  logic                    in_collect;
  logic                    accept;
  logic                    complete;
  logic                    err_now;

  assign in_collect = (state == COLLECT);
  assign uop_rdy    = !flush && ((state == IDLE) || ((state == DONE) && opnd_rdy));
  assign accept     = uop_vld && uop_rdy;
  assign opnd_vld   = (state == DONE);

  // Ports are scanned in ascending order so the highest-numbered port wins a shared slot.
  // A slot index only matches when rs_idx < SRC_NUM, since s never exceeds SLOTS-1.
  always_comb begin
    hit      = '0;
    hit_data = '0;
    port_ok  = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      for (int unsigned p = 0; p < VRF_RPORT_NUM; p++) begin
        if (in_collect && rd_vld[p] && need_q[s] &&
            (rd_rs_idx[p*RS_IDX_WIDTH +: RS_IDX_WIDTH] == RS_IDX_WIDTH'(s / FIELD_NUM)) &&
            (rd_field_idx[p*FIELD_IDX_WIDTH +: FIELD_IDX_WIDTH] == FIELD_IDX_WIDTH'(s % FIELD_NUM))) begin
          hit[s]                        = 1'b1;
          hit_data[s*VFULEN +: VFULEN]  = rd_data[p*VFULEN +: VFULEN];
          port_ok[p]                    = 1'b1;
        end
      end
    end
  end

  assign complete = in_collect && (((got_q | hit) & need_q) == need_q);
  assign err_now  = !flush && |(rd_vld & ~port_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      need_q    <= '0;
      got_q     <= '0;
      opnd_tag  <= '0;
      opnd_data <= '0;
      err_unexp <= 1'b0;
    end else begin
      err_unexp <= err_now;
      if (flush) begin
        state <= IDLE;
        got_q <= '0;
      end else if (accept) begin
        opnd_tag <= uop_tag;
        need_q   <= uop_need;
        got_q    <= '0;
        state    <= (uop_need == '0) ? DONE : COLLECT;
      end else if (in_collect) begin
        got_q <= got_q | hit;
        for (int unsigned s = 0; s < SLOTS; s++) begin
          if (hit[s]) opnd_data[s*VFULEN +: VFULEN] <= hit_data[s*VFULEN +: VFULEN];
        end
        if (complete) state <= DONE;
      end else if ((state == DONE) && opnd_rdy) begin
        state <= IDLE;
      end
    end
  end

`ifdef VOC_MASK_CAPTURE_EN
  logic vm_q;

  // v0 is resampled every COLLECT cycle, so DONE holds the value seen on the completing cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vm_q      <= 1'b0;
      opnd_mask <= '0;
    end else if (!flush) begin
      if (accept) begin
        vm_q      <= uop_vm;
        opnd_mask <= uop_vm ? data_v0 : '1;
      end else if (in_collect && vm_q) begin
        opnd_mask <= data_v0;
      end
    end
  end
`endif

endmodule

// File: doc/vrf_operand_collector.md
Name: vrf_operand_collector

Overview:
- Sits directly downstream of the vector register file read stage; one instance per vector FU issue slot.
- Accepts one issued uop, then gathers its source operand fields from the VRF read-return packet over one or more cycles, since bank conflicts can spread a read across several cycles.
- Presents the fully assembled operand set to the FU with a valid/ready handshake.
- A single-entry buffer with back-to-back capability.

Parameters:
- VRF_RPORT_NUM, 4, number of VRF read-return ports.
- VFULEN, 64, width of one operand field (one bank word).
- SRC_NUM, 3, source operands per uop (vs1, vs2, vs3/vd).
- FIELD_NUM, 2, fields per operand (VLEN = FIELD_NUM*VFULEN).
- TAG_WIDTH, 6, uop tag width.
- RS_IDX_WIDTH, 2, width of the per-port source index.
- FIELD_IDX_WIDTH, 1, width of the per-port field index.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any held uop
- uop_vld  in  1  issue request
- uop_rdy  out  1  collector can accept a uop
- uop_tag  in  TAG_WIDTH  uop tag
- uop_need  in  SRC_NUM*FIELD_NUM  required-field mask; bit s*FIELD_NUM+f
- rd_vld  in  VRF_RPORT_NUM  per-port read data valid
- rd_rs_idx  in  VRF_RPORT_NUM*RS_IDX_WIDTH  source index per port
- rd_field_idx  in  VRF_RPORT_NUM*FIELD_IDX_WIDTH  field index per port
- rd_data  in  VRF_RPORT_NUM*VFULEN  read data per port
- opnd_vld  out  1  operand set complete
- opnd_rdy  in  1  FU accepts
- opnd_tag  out  TAG_WIDTH  tag of presented uop
- opnd_data  out  SRC_NUM*FIELD_NUM*VFULEN  assembled fields; slot s*FIELD_NUM+f
- err_unexp  out  1  one-cycle pulse: valid return for a slot not needed, or while idle

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; opnd_vld = 0; opnd_tag = 0; opnd_data = 0; err_unexp = 0.
  - got mask = 0; uop_rdy = 1 once out of reset.
- States: IDLE, COLLECT, DONE.
- uop_rdy = (state == IDLE) | (state == DONE & opnd_rdy). It is combinational from opnd_rdy, with no dependence on uop_vld.
- Accept occurs when uop_vld & uop_rdy:
  - latch tag and need; clear the got mask;
  - next state = DONE if uop_need == 0, else COLLECT.
- COLLECT, per cycle, for each port p with rd_vld[p]:
  - slot = rs_idx*FIELD_NUM + field_idx.
  - If rs_idx < SRC_NUM and need[slot]: write rd_data[p] into the slot and set got[slot].
  - Otherwise: drop the data and pulse err_unexp the next cycle.
- COLLECT collisions and repeats:
  - Multiple ports hitting the same slot in one cycle: the highest-numbered port wins.
  - A repeat hit on a slot already in got overwrites the data. This is not an error.
- COLLECT -> DONE when ((got | hits_this_cycle) & need) == need.
  - opnd_vld rises the cycle after the last needed field arrives; minimum latency is 1 cycle.
- DONE:
  - opnd_vld = 1; opnd_tag and opnd_data stay stable until opnd_rdy.
  - On opnd_vld & opnd_rdy: go to IDLE, or accept a new uop in the same cycle (back-to-back).
- Unneeded slots in opnd_data are undefined. The bench compares only needed slots.
- Returns while IDLE or DONE are ignored and pulse err_unexp (next cycle).
- flush takes priority over all events:
  - next state = IDLE, opnd_vld = 0, got = 0.
  - A uop_vld in the flush cycle is not accepted; uop_rdy = 0 while flush = 1.
- Reset asserted mid-COLLECT or mid-DONE discards the uop immediately (asynchronous).

Optional Feature:
- Macro VOC_MASK_CAPTURE_EN.
- When defined, the block adds the following ports:
  - input uop_vm (1), the mask-enabled flag;
  - input data_v0 (FIELD_NUM*VFULEN), the architectural v0 from the register file;
  - output opnd_mask (FIELD_NUM*VFULEN), reset value 0.
- On accept with uop_vm = 0, opnd_mask is captured as all-ones.
- For uop_vm = 1, data_v0 is sampled each COLLECT cycle. The value sampled in the cycle completion is detected is held in DONE.
- When undefined: none of these ports exist, and behaviour is otherwise identical.

Test Plan:
- Single uop, need = 6'b000011, rd_vld = 4'b0011 carrying slot0 = 0xA5.., slot1 = 0x5A.. in one cycle -> opnd_vld one cycle later, opnd_data slots 0/1 match, opnd_tag = issued tag.
- Need = 6'b111111 returned two fields per cycle over 3 cycles -> opnd_vld 1 cycle after the 3rd return; held stable with opnd_rdy = 0 for 5 cycles; drops after the handshake.
- Back-to-back: DONE with opnd_rdy = 1 and uop_vld = 1 (tag 7) -> uop_rdy = 1, new uop in COLLECT next cycle, old opnd_vld deasserted.
- Port collision: ports 1 and 3 both target slot 2 with values 0x11 and 0x33 -> slot 2 = 0x33. A return to an unneeded slot -> err_unexp pulses for exactly 1 cycle.
- Need = 0 -> opnd_vld the cycle after accept. flush in COLLECT -> IDLE next cycle, no opnd_vld; rstn pulse in DONE -> opnd_vld = 0 immediately.
- With VOC_MASK_CAPTURE_EN: uop_vm = 1, data_v0 = 0xF0F0.. -> opnd_mask = 0xF0F0..; uop_vm = 0 -> opnd_mask = all-ones.
